mul8_seq: RTL and testbench

MUL8_SEQ -- requirements
Module: mul8_seq

---
 rtl/mul8_seq.sv | 136 +++++++++++++
 tb/tb_mul8_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul8_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier: eight RUN iterations per product,
// each adding the multiplicand into the upper accumulator half through a ripple adder.

module Mul8FullAdder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

module Mul8RippleAdder (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout,
    output logic       o_ovf
);
    logic [8:0] w_carry;

    assign w_carry[0] = i_cin;

    genvar gBit;
    generate
        for (gBit = 0; gBit < 8; gBit++) begin : gStage
            Mul8FullAdder uFa (
                .i_a   (i_a[gBit]),
                .i_b   (i_b[gBit]),
                .i_cin (w_carry[gBit]),
                .o_sum (o_sum[gBit]),
                .o_cout(w_carry[gBit+1])
            );
        end
    endgenerate

    assign o_cout = w_carry[8];
    // Signed overflow: carry into the MSB differs from carry out of it.
    assign o_ovf  = w_carry[8] ^ w_carry[7];
endmodule

module mul8_seq (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT       r_state;
    logic [15:0] r_acc;
    logic [7:0]  r_mcand;
    logic [2:0]  r_count;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_product;

    logic [7:0]  w_addend;
    logic [7:0]  w_sum;
    logic        w_carry;
    logic        w_unusedOvf;
    logic [15:0] w_shifted;

    // A clear multiplier LSB gates the addend to zero, so the sum is just the high half.
    assign w_addend = r_mcand & {8{r_acc[0]}};

    Mul8RippleAdder uAdder (
        .i_a   (r_acc[15:8]),
        .i_b   (w_addend),
        .i_cin (1'b0),
        .o_sum (w_sum),
        .o_cout(w_carry),
        .o_ovf (w_unusedOvf)
    );

    assign w_shifted = {w_carry, w_sum, r_acc[7:1]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_acc     <= 16'h0000;
            r_mcand   <= 8'h00;
            r_count   <= 3'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_product <= 16'h0000;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_mcand <= a;
                        r_acc   <= {8'h00, b};
                        r_count <= 3'd0;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                end
                RUN: begin
                    r_acc   <= w_shifted;
                    r_count <= r_count + 3'd1;
                    if (r_count == 3'd7) begin
                        r_product <= w_shifted;
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;
endmodule

// File: tb/tb_mul8_seq.sv
// Self-checking bench for mul8_seq: directed scenarios plus random and swept operands
// compared against a plain arithmetic multiply with a fixed 8-cycle latency.

module tb_mul8_seq;
    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int nChecks = 0;
    int nFails  = 0;

    localparam int LATENCY = 8;

    always #5 clk = ~clk;

    mul8_seq dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .product(product)
    );

    function automatic logic [15:0] refMul(input logic [7:0] x, input logic [7:0] y);
        int p;
        p = int'(x) * int'(y);
        return p[15:0];
    endfunction

    // Called at a negedge; returns at the negedge where done is seen (or after the budget).
    // Operands are scrambled during RUN so any late sampling corrupts the product.
    task automatic runOp(input logic [7:0] ia, input logic [7:0] ib,
                         output logic [15:0] prod, output int busyCycles, output int lat);
        start = 1'b1;
        a = ia;
        b = ib;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        busyCycles = 0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (done) begin
                lat = i - 1;
                break;
            end
            if (busy) busyCycles++;
            @(negedge clk);
        end
        prod = product;
    endtask

    task automatic test_reset();
        logic [15:0] p;
        int bc, lat;
        rstn = 1'b0;
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        repeat (3) @(negedge clk);
        nChecks++;
        if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        nChecks++;
        if (done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done got %b want 0", done); end
        nChecks++;
        if (product !== 16'h0000) begin nFails++; $display("[TB] FAIL reset_product got %h want 0000", product); end
        // First edge with rstn high also carries start.
        rstn = 1'b1;
        runOp(8'd6, 8'd7, p, bc, lat);
        nChecks++;
        if (lat !== LATENCY) begin nFails++; $display("[TB] FAIL first_accept_latency got %0d want %0d", lat, LATENCY); end
        nChecks++;
        if (p !== 16'd42) begin nFails++; $display("[TB] FAIL first_accept_product got %0d want 42", p); end
    endtask

    task automatic test_basic();
        logic [15:0] p;
        int bc, lat;
        runOp(8'd13, 8'd11, p, bc, lat);
        nChecks++;
        if (bc !== LATENCY) begin nFails++; $display("[TB] FAIL basic_busy_cycles got %0d want %0d", bc, LATENCY); end
        nChecks++;
        if (lat !== LATENCY) begin nFails++; $display("[TB] FAIL basic_latency got %0d want %0d", lat, LATENCY); end
        nChecks++;
        if (p !== refMul(8'd13, 8'd11)) begin nFails++; $display("[TB] FAIL basic_product got %0d want 143", p); end
        nChecks++;
        if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL basic_busy_at_done got %b want 0", busy); end
        @(negedge clk);
        nChecks++;
        if (done !== 1'b0) begin nFails++; $display("[TB] FAIL basic_done_pulse_width got %b want 0", done); end
        nChecks++;
        if (product !== 16'd143) begin nFails++; $display("[TB] FAIL basic_product_hold got %0d want 143", product); end
    endtask

    task automatic test_corners();
        logic [15:0] p;
        int bc, lat;
        runOp(8'hFF, 8'hFF, p, bc, lat);
        nChecks++;
        if (p !== 16'hFE01) begin nFails++; $display("[TB] FAIL max_product got %h want fe01", p); end
        nChecks++;
        if (lat !== LATENCY) begin nFails++; $display("[TB] FAIL max_latency got %0d want %0d", lat, LATENCY); end
        runOp(8'h00, 8'hA5, p, bc, lat);
        nChecks++;
        if (p !== 16'h0000) begin nFails++; $display("[TB] FAIL zero_product got %h want 0000", p); end
        nChecks++;
        if (lat !== LATENCY) begin nFails++; $display("[TB] FAIL zero_latency got %0d want %0d", lat, LATENCY); end
        nChecks++;
        if (bc !== LATENCY) begin nFails++; $display("[TB] FAIL zero_busy_cycles got %0d want %0d", bc, LATENCY); end
    endtask

    task automatic test_start_ignored();
        int d = -1;
        int bc = 0;
        logic [15:0] p = 16'hxxxx;
        start = 1'b1;
        a = 8'd7;
        b = 8'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j <= 20; j++) begin
            if (done) begin
                d = j;
                p = product;
                break;
            end
            if (busy) bc++;
            if (j == 2) begin
                start = 1'b1;
                a = 8'd2;
                b = 8'd2;
            end else if (j == 3) begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        nChecks++;
        if (d !== LATENCY) begin nFails++; $display("[TB] FAIL ignore_latency got %0d want %0d", d, LATENCY); end
        nChecks++;
        if (p !== refMul(8'd7, 8'd9)) begin nFails++; $display("[TB] FAIL ignore_product got %0d want 63", p); end
        nChecks++;
        if (bc !== LATENCY) begin nFails++; $display("[TB] FAIL ignore_busy_cycles got %0d want %0d", bc, LATENCY); end
    endtask

    task automatic test_back_to_back();
        int d1 = -1;
        int d2 = -1;
        logic [15:0] p1 = 16'hxxxx;
        logic [15:0] p2 = 16'hxxxx;
        start = 1'b1;
        a = 8'd3;
        b = 8'd5;
        @(posedge clk);
        @(negedge clk);
        a = 8'd200;
        b = 8'd100;
        for (int j = 0; j < 40; j++) begin
            if (done) begin
                if (d1 < 0) begin
                    d1 = j;
                    p1 = product;
                end else begin
                    d2 = j;
                    p2 = product;
                    break;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        nChecks++;
        if (d1 !== LATENCY) begin nFails++; $display("[TB] FAIL b2b_first_done got %0d want %0d", d1, LATENCY); end
        nChecks++;
        if (d2 - d1 !== LATENCY + 1) begin nFails++; $display("[TB] FAIL b2b_spacing got %0d want %0d", d2 - d1, LATENCY + 1); end
        nChecks++;
        if (p1 !== refMul(8'd3, 8'd5)) begin nFails++; $display("[TB] FAIL b2b_product1 got %0d want 15", p1); end
        nChecks++;
        if (p2 !== refMul(8'd200, 8'd100)) begin nFails++; $display("[TB] FAIL b2b_product2 got %0d want 20000", p2); end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] p;
        int bc, lat;
        runOp(8'h12, 8'h34, p, bc, lat);
        nChecks++;
        if (p !== refMul(8'h12, 8'h34)) begin nFails++; $display("[TB] FAIL pre_abort_product got %h want %h", p, refMul(8'h12, 8'h34)); end
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (j == 1) begin
                nChecks++;
                if (product !== 16'h03A8) begin nFails++; $display("[TB] FAIL hold_during_run got %h want 03a8", product); end
            end
            if (j == 3) rstn = 1'b0;
            @(negedge clk);
        end
        nChecks++;
        if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
        nChecks++;
        if (done !== 1'b0) begin nFails++; $display("[TB] FAIL abort_done got %b want 0", done); end
        nChecks++;
        if (product !== 16'h0000) begin nFails++; $display("[TB] FAIL abort_product got %h want 0000", product); end
        rstn = 1'b1;
        repeat (10) begin
            @(negedge clk);
            nChecks++;
            if (done !== 1'b0) begin nFails++; $display("[TB] FAIL abort_stray_done got %b want 0", done); end
        end
        runOp(8'hFF, 8'hFF, p, bc, lat);
        nChecks++;
        if (p !== 16'hFE01) begin nFails++; $display("[TB] FAIL after_abort_product got %h want fe01", p); end
        nChecks++;
        if (lat !== LATENCY) begin nFails++; $display("[TB] FAIL after_abort_latency got %0d want %0d", lat, LATENCY); end
    endtask

    task automatic test_random();
        logic [15:0] p;
        logic [7:0] ra, rb;
        int bc, lat;
        for (int n = 0; n < 5000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            runOp(ra, rb, p, bc, lat);
            nChecks++;
            if (p !== refMul(ra, rb)) begin nFails++; $display("[TB] FAIL random_product a=%h b=%h got %h want %h", ra, rb, p, refMul(ra, rb)); end
            nChecks++;
            if (lat !== LATENCY) begin nFails++; $display("[TB] FAIL random_latency a=%h b=%h got %0d want %0d", ra, rb, lat, LATENCY); end
        end
    endtask

    task automatic test_sweep();
        logic [15:0] p;
        logic [7:0] bList [4] = '{8'h00, 8'h01, 8'h80, 8'hFF};
        logic [7:0] sa;
        int bc, lat;
        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                sa = 8'(ai);
                runOp(sa, bList[bi], p, bc, lat);
                nChecks++;
                if (p !== refMul(sa, bList[bi])) begin nFails++; $display("[TB] FAIL sweep_product a=%h b=%h got %h want %h", sa, bList[bi], p, refMul(sa, bList[bi])); end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rstn = 1'b0;
        start = 1'b0;
        a = 8'h00;
        b = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic();
        test_corners();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
